// File: rtl/miss_fill_unit.sv
// Cache miss fill unit: fetches one block word-by-word from memory and hands it to the cache.
module miss_fill_unit #(
    parameter int unsigned sizeOfAddress   = 32,
    parameter int unsigned blockSize       = 8,
    parameter int unsigned bitsOfBlockSize = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       miss_valid,
    input  logic [sizeOfAddress-1:0]   miss_addr,
    output logic                       miss_ready,
    output logic                       mem_req,
    output logic [sizeOfAddress-1:0]   mem_addr,
    input  logic                       mem_gnt,
    input  logic                       mem_rvalid,
    input  logic [31:0]                mem_rdata,
    output logic                       fill_valid,
    input  logic                       fill_ready,
    output logic [sizeOfAddress-1:0]   fill_addr,
    output logic [blockSize*8-1:0]     fill_data,
    output logic [15:0]                fill_count
);

    localparam int unsigned AW    = sizeOfAddress;
    localparam int unsigned DW    = blockSize * 8;
    localparam int unsigned WORDS = blockSize / 4;
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [AW-1:0] OFS_MASK = AW'((64'd1 << bitsOfBlockSize) - 64'd1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [AW-1:0]    base, base_d;
    logic [31:0]      buffer   [WORDS];
    logic [31:0]      buffer_d [WORDS];
    logic [AW-1:0]    fill_addr_d;
    logic [DW-1:0]    fill_data_d;
    logic [15:0]      fill_count_d;
    logic [AW-1:0]    mem_addr_d;
    logic             miss_ready_d;
    logic             mem_req_d;
    logic             fill_valid_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, datapath updates and next values of the registered outputs
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        base_d       = base;
        buffer_d     = buffer;
        fill_addr_d  = fill_addr;
        fill_data_d  = fill_data;
        fill_count_d = fill_count;

        case (state)
            IDLE: begin
                if (miss_valid) begin
                    base_d  = miss_addr & ~OFS_MASK;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    buffer_d[cnt] = mem_rdata;
                    if (cnt == CNT_W'(WORDS - 1)) begin
                        // Snapshot the block so fill outputs stay put during the next fetch
                        fill_addr_d = base;
                        for (int i = 0; i < int'(WORDS); i++) begin
                            fill_data_d[32*i +: 32] = buffer_d[i];
                        end
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt + CNT_W'(1);
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                if (fill_ready) begin
                    if (fill_count != 16'hFFFF) begin
                        fill_count_d = fill_count + 16'd1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        miss_ready_d = (state_d == IDLE);
        mem_req_d    = (state_d == REQ);
        fill_valid_d = (state_d == DONE);
        mem_addr_d   = (base_d >> 2) + AW'(cnt_d);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            base       <= '0;
            fill_addr  <= '0;
            fill_data  <= '0;
            fill_count <= '0;
            mem_addr   <= '0;
            miss_ready <= 1'b1;
            mem_req    <= 1'b0;
            fill_valid <= 1'b0;
            for (int i = 0; i < int'(WORDS); i++) begin
                buffer[i] <= '0;
            end
        end else begin
            cnt        <= cnt_d;
            base       <= base_d;
            fill_addr  <= fill_addr_d;
            fill_data  <= fill_data_d;
            fill_count <= fill_count_d;
            mem_addr   <= mem_addr_d;
            miss_ready <= miss_ready_d;
            mem_req    <= mem_req_d;
            fill_valid <= fill_valid_d;
            for (int i = 0; i < int'(WORDS); i++) begin
                buffer[i] <= buffer_d[i];
            end
        end
    end

endmodule

// File: tb/tb_miss_fill_unit.sv
// Scoreboard bench for miss_fill_unit with default parameters (2 words per block).
module tb_miss_fill_unit;

    logic        clk;
    logic        rst;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        miss_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        fill_valid;
    logic        fill_ready;
    logic [31:0] fill_addr;
    logic [63:0] fill_data;
    logic [15:0] fill_count;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } fill_t;

    fill_t       sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_count = 16'd0;
    logic [63:0] last_data = 64'd0;

    miss_fill_unit dut (
        .clk        (clk),
        .rst        (rst),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .miss_ready (miss_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .fill_count (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs changed 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full fill of one block; expected block pushed at accept, popped when fill_valid shows
    task automatic run_fill(input logic [31:0] addr, input logic [31:0] w0, input logic [31:0] w1,
                            input int gnt_stall, input int ready_stall, input bit spur);
        fill_t       exp;
        int          edges;
        bit          ok;
        logic [31:0] base;
        base = addr & ~32'h7;
        exp.addr = base;
        exp.data = {w1, w0};
        sb.push_back(exp);
        miss_valid = 1'b1;
        miss_addr  = addr;
        tick();
        miss_valid = 1'b0;
        miss_addr  = $urandom;
        edges = 0;
        for (int w = 0; w < 2; w++) begin
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                if (mem_req === 1'b1) ok = 1'b1;
                else begin tick(); edges++; end
            end
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL mem_req_timeout word=%0d got mem_req=%b want 1", w, mem_req);
                return;
            end
            n_vec++;
            if (mem_addr !== (base >> 2) + 32'(w)) begin
                n_err++;
                $display("FAIL mem_addr word=%0d got %h want %h", w, mem_addr, (base >> 2) + 32'(w));
            end
            if (w == 0) begin
                for (int s = 0; s < gnt_stall; s++) begin
                    tick(); edges++;
                    n_vec++;
                    if (mem_req !== 1'b1 || mem_addr !== (base >> 2) || fill_valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL gnt_stall cyc=%0d got req=%b addr=%h fv=%b want 1 %h 0",
                                 s, mem_req, mem_addr, fill_valid, base >> 2);
                    end
                end
            end
            mem_gnt = 1'b1;
            if (spur) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_BEEF;
            end
            tick(); edges++;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = (w == 0) ? w0 : w1;
            tick(); edges++;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (fill_valid === 1'b1) ok = 1'b1;
            else begin tick(); edges++; end
        end
        n_vec++;
        if (!ok || edges != 4 + gnt_stall) begin
            n_err++;
            $display("FAIL fill_latency got %0d edges (seen=%b) want %0d", edges, ok, 4 + gnt_stall);
        end
        if (!ok) return;
        exp = sb.pop_front();
        n_vec++;
        if (fill_addr !== exp.addr || fill_data !== exp.data || fill_count !== exp_count) begin
            n_err++;
            $display("FAIL fill_block got addr=%h data=%h cnt=%h want %h %h %h",
                     fill_addr, fill_data, fill_count, exp.addr, exp.data, exp_count);
        end
        for (int s = 0; s < ready_stall; s++) begin
            miss_valid = 1'b1;
            miss_addr  = 32'h0000_9000;
            tick();
            n_vec++;
            if (fill_valid !== 1'b1 || fill_data !== exp.data || miss_ready !== 1'b0 || mem_req !== 1'b0) begin
                n_err++;
                $display("FAIL ready_stall cyc=%0d got fv=%b data=%h mr=%b req=%b want 1 %h 0 0",
                         s, fill_valid, fill_data, miss_ready, mem_req, exp.data);
            end
        end
        fill_ready = 1'b1;
        tick();
        fill_ready = 1'b0;
        miss_valid = 1'b0;
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        last_data = exp.data;
        n_vec++;
        if (fill_valid !== 1'b0 || miss_ready !== 1'b1 || mem_req !== 1'b0 || fill_count !== exp_count) begin
            n_err++;
            $display("FAIL fill_done got fv=%b mr=%b req=%b cnt=%h want 0 1 0 %h",
                     fill_valid, miss_ready, mem_req, fill_count, exp_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_vec++;
        if (miss_ready !== 1'b1 || mem_req !== 1'b0 || fill_valid !== 1'b0 || fill_count !== 16'h0 ||
            fill_addr !== 32'h0 || fill_data !== 64'h0 || mem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset got mr=%b req=%b fv=%b cnt=%h fa=%h fd=%h ma=%h want 1 0 0 0 0 0 0",
                     miss_ready, mem_req, fill_valid, fill_count, fill_addr, fill_data, mem_addr);
        end
    endtask

    // Block 0x1230 spans word addresses 0x48C and 0x48D
    task automatic test_basic();
        run_fill(32'h0000_1234, 32'hAAAA_0001, 32'hBBBB_0002, 0, 0, 1'b0);
    endtask

    task automatic test_mem_stall();
        run_fill(32'h0004_0FFC, 32'h1111_2222, 32'h3333_4444, 5, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_fill(32'h0000_2008, 32'h5555_6666, 32'h7777_8888, 0, 3, 1'b0);
        run_fill(32'h0000_9000, 32'h9999_AAAA, 32'hBBBB_CCCC, 0, 0, 1'b0);
    endtask

    task automatic test_spurious_rvalid();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (miss_ready !== 1'b1 || mem_req !== 1'b0 || fill_valid !== 1'b0 || fill_data !== last_data) begin
                n_err++;
                $display("FAIL idle_rvalid got mr=%b req=%b fv=%b data=%h want 1 0 0 %h",
                         miss_ready, mem_req, fill_valid, fill_data, last_data);
            end
        end
        mem_rvalid = 1'b0;
        run_fill(32'hFFFF_FFF8, 32'h0BAD_F00D, 32'hCAFE_0123, 2, 0, 1'b1);
    endtask

    task automatic test_reset_mid_fill();
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_3000;
        tick();
        miss_valid = 1'b0;
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; tick(); mem_rvalid = 1'b0;
        mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
        n_vec++;
        if (mem_req !== 1'b0 || fill_valid !== 1'b0 || miss_ready !== 1'b0) begin
            n_err++;
            $display("FAIL wait_state got req=%b fv=%b mr=%b want 0 0 0", mem_req, fill_valid, miss_ready);
        end
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        fill_ready = 1'b1;
        mem_rdata  = 32'h8765_4321;
        tick();
        rst        = 1'b0;
        fill_ready = 1'b0;
        exp_count  = 16'd0;
        last_data  = 64'd0;
        n_vec++;
        if (miss_ready !== 1'b1 || mem_req !== 1'b0 || fill_valid !== 1'b0 || fill_count !== 16'h0) begin
            n_err++;
            $display("FAIL reset_mid got mr=%b req=%b fv=%b cnt=%h want 1 0 0 0",
                     miss_ready, mem_req, fill_valid, fill_count);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (fill_valid !== 1'b0 || mem_req !== 1'b0 || miss_ready !== 1'b1 || fill_count !== 16'h0) begin
                n_err++;
                $display("FAIL late_rvalid cyc=%0d got fv=%b req=%b mr=%b cnt=%h want 0 0 1 0",
                         i, fill_valid, mem_req, miss_ready, fill_count);
            end
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_fill($urandom, $urandom, $urandom, 0, 0, 1'b0);
        end
    endtask

    // Counter is preloaded near the top rather than driven there by ~65k fills
    task automatic test_saturation();
        force dut.fill_count = 16'hFFFC;
        tick();
        release dut.fill_count;
        exp_count = 16'hFFFC;
        for (int i = 0; i < 5; i++) begin
            run_fill(32'h0000_4000 + 32'(8 * i), 32'h0 + 32'(i), 32'hF000_0000 + 32'(i), 0, 0, 1'b0);
        end
        n_vec++;
        if (fill_count !== 16'hFFFF) begin
            n_err++;
            $display("FAIL saturation got %h want ffff", fill_count);
        end
    endtask

    initial begin
        rst        = 1'b1;
        miss_valid = 1'b0;
        miss_addr  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        fill_ready = 1'b0;
        test_reset();
        test_basic();
        test_mem_stall();
        test_backpressure();
        test_spurious_rvalid();
        test_reset_mid_fill();
        test_back_to_back();
        test_saturation();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
